id_stage_sb: RTL and testbench

Parametrised successor to the single-cycle decode/hazard stage: holds the architectural register file, a per-register pending-load scoreboard and the ID/EX pipeline register. It generalises the one-cycle load-use stall to loads of arbitrary memory latency: any instruction touching a register with an outstanding load stalls until that load writes back. It sits between the decoder (which supplies control and register addresses) and EX; WB writes back into it.

---
 rtl/id_pkg.sv | 27 ++
 rtl/id_regfile.sv | 45 ++++
 rtl/id_stage_sb.sv | 124 ++++++++++++
 tb/tb_id_stage_sb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the decode/hazard stage: address-width helper,
// layout of the opaque control bundle handed to EX, and the bubble value.
package id_pkg;

  // Register-address width for a register file of n entries.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default control-bundle width and field offsets. The stage itself never
  // looks inside the bundle; EX decodes these fields.
  localparam int CTRL_W_DEFAULT     = 12;
  localparam int CTRL_ALU_OP_LSB    = 0;
  localparam int CTRL_ALU_OP_W      = 4;
  localparam int CTRL_ALU_SRC_BIT   = 4;
  localparam int CTRL_MEM_WRITE_BIT = 5;
  localparam int CTRL_BRANCH_BIT    = 6;
  localparam int CTRL_JUMP_BIT      = 7;
  localparam int CTRL_WB_SEL_LSB    = 8;
  localparam int CTRL_WB_SEL_W      = 2;
  localparam int CTRL_IMM_SEL_LSB   = 10;
  localparam int CTRL_IMM_SEL_W     = 2;

  // A bubble carries all-zero control so EX does nothing with it.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one write port, x0 hard-wired to zero, optional same-cycle write bypass.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREG];

  // Write port; entry 0 is never written so it always reads back zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file must read zero straight after reset, so every
      // entry is a resettable flop rather than an uninitialised RAM.
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      // NOTE: state is updated with <= so all flops sample the same pre-edge values.
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports with optional forwarding of the write being performed this cycle.
  always_comb begin
    // NOTE: outputs get a default first so no path through the block leaves a latch.
    rs1_data = mem[rs1_addr];
    rs2_data = mem[rs2_addr];
    if ((WB_BYPASS != 0) && we && (wr_addr == rs1_addr) && (rs1_addr != '0)) rs1_data = wr_data;
    if ((WB_BYPASS != 0) && we && (wr_addr == rs2_addr) && (rs2_addr != '0)) rs2_data = wr_data;
  end

endmodule

// File: rtl/id_stage_sb.sv
// Decode stage with a per-register pending-load scoreboard: stalls any
// instruction touching a register whose load has not yet written back, and
// holds the ID/EX pipeline register.
module id_stage_sb
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int CTRL_W    = 12,
  parameter int WB_BYPASS = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs1_addr,
  input  logic [AW-1:0]     id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [AW-1:0]     id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [AW-1:0]     wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              wb_load_done,
  output logic              stall,
  output logic              if_write,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [AW-1:0]     ex_rs1_addr,
  output logic [AW-1:0]     ex_rs2_addr,
  output logic [AW-1:0]     ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [NREG-1:0]   pending
);

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [NREG-1:0] load_clr;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] pending_next;
  logic            hazard;
  logic            issue;

  id_regfile #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_reg_write),
    .wr_addr  (wb_rd_addr),
    .wr_data  (wb_data)
  );

  // Hazard detection, issue decision and next scoreboard contents.
  always_comb begin
    load_clr = '0;
    if (wb_reg_write && wb_load_done) load_clr[wb_rd_addr] = 1'b1;
    // A retiring load only unblocks its consumer this cycle when the operand
    // can be bypassed; without bypass the consumer waits for the rf write.
    pend_eff = (WB_BYPASS != 0) ? (pending & ~load_clr) : pending;
    hazard   = (id_rs1_used  && pend_eff[id_rs1_addr])
            || (id_rs2_used  && pend_eff[id_rs2_addr])
            || (id_reg_write && pend_eff[id_rd_addr]);
    stall    = id_valid && hazard && !flush;
    issue    = id_valid && !stall && !flush;
    // Clear first so a new load to the same register wins over its retirement.
    pending_next = pending & ~load_clr;
    if (issue && id_mem_read && id_reg_write && (id_rd_addr != '0)) pending_next[id_rd_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign if_write = ~stall;

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  // ID/EX pipeline register: capture on issue, otherwise insert a bubble
  // while leaving the data/address fields as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (issue) begin
      ex_valid     <= 1'b1;
      ex_ctrl      <= id_ctrl;
      ex_rs1_data  <= rs1_data;
      ex_rs2_data  <= rs2_data;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
    end else begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= CTRL_W'(CTRL_BUBBLE);
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_sb.sv
// Self-checking bench for id_stage_sb: directed scenarios plus randomized
// traffic, all checked against a list-of-outstanding-loads reference model.
module tb_id_stage_sb;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int CTRL_W = 12;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [AW-1:0]     id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, wb_reg_write, wb_load_done;
  logic [XLEN-1:0]   wb_data;
  logic              stall, if_write, ex_valid, ex_reg_write, ex_mem_read;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data;
  logic [AW-1:0]     ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [NREG-1:0]   pending;

  id_stage_sb dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_ctrl(id_ctrl), .flush(flush), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_load_done(wb_load_done),
    .stall(stall), .if_write(if_write), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int          rs1;
    bit          rs1u;
    int          rs2;
    bit          rs2u;
    int          rd;
    bit          rw;
    bit          mr;
    logic [11:0] ctrl;
    bit          flush;
    bit          wbw;
    int          wbrd;
    logic [31:0] wbdata;
    bit          wbld;
  } stim_t;

  // Reference model: register contents plus the list of registers that have
  // a load in flight.
  logic [31:0] m_rf [NREG];
  int          m_out [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          obs_stall;
  bit          exp_stall;

  function automatic stim_t nop();
    stim_t s;
    s = '{valid: 0, rs1: 0, rs1u: 0, rs2: 0, rs2u: 0, rd: 0, rw: 0, mr: 0, ctrl: 12'h0,
          flush: 0, wbw: 0, wbrd: 0, wbdata: 32'h0, wbld: 0};
    return s;
  endfunction

  function automatic stim_t load(int rd);
    stim_t s = nop();
    s.valid = 1; s.rd = rd; s.rw = 1; s.mr = 1; s.rs1 = 2; s.rs1u = 1; s.ctrl = 12'h3A1;
    return s;
  endfunction

  function automatic stim_t alu(int rd, int rs1, int rs2);
    stim_t s = nop();
    s.valid = 1; s.rd = rd; s.rw = 1; s.rs1 = rs1; s.rs1u = 1; s.rs2 = rs2; s.rs2u = 1;
    s.ctrl = 12'h0C5;
    return s;
  endfunction

  function automatic bit in_flight(int r);
    foreach (m_out[i]) if (m_out[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // A register blocks ID while its load is outstanding and not retiring now.
  function automatic bit busy(int r, stim_t s);
    return in_flight(r) && !(s.wbw && s.wbld && s.wbrd == r);
  endfunction

  function automatic logic [31:0] m_read(int r, stim_t s);
    if (r == 0) return 32'h0;
    if (s.wbw && s.wbrd == r) return s.wbdata;
    return m_rf[r];
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] v = '0;
    foreach (m_out[i]) v[m_out[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_out.delete();
  endtask

  task automatic drive(stim_t s);
    id_valid = s.valid; id_rs1_addr = 5'(s.rs1); id_rs1_used = s.rs1u;
    id_rs2_addr = 5'(s.rs2); id_rs2_used = s.rs2u; id_rd_addr = 5'(s.rd);
    id_reg_write = s.rw; id_mem_read = s.mr; id_ctrl = s.ctrl; flush = s.flush;
    wb_reg_write = s.wbw; wb_rd_addr = 5'(s.wbrd); wb_data = s.wbdata; wb_load_done = s.wbld;
  endtask

  // One clock cycle: drive, compare stall, advance model, compare EX and scoreboard.
  task automatic step(stim_t s);
    bit e_issue;
    logic [31:0] e_d1, e_d2;
    @(negedge clk);
    drive(s);
    #1;
    exp_stall = s.valid && !s.flush &&
                ((s.rs1u && busy(s.rs1, s)) || (s.rs2u && busy(s.rs2, s)) || (s.rw && busy(s.rd, s)));
    e_issue = s.valid && !exp_stall && !s.flush;
    obs_stall = stall;
    n_cmp++;
    if (stall !== exp_stall || if_write !== !exp_stall) begin
      n_bad++;
      $display("FAIL stall: got stall=%0b if_write=%0b, want stall=%0b", stall, if_write, exp_stall);
    end
    e_d1 = m_read(s.rs1, s);
    e_d2 = m_read(s.rs2, s);
    if (s.wbw && s.wbrd != 0) m_rf[s.wbrd] = s.wbdata;
    if (s.wbw && s.wbld)
      for (int i = m_out.size() - 1; i >= 0; i--) if (m_out[i] == s.wbrd) m_out.delete(i);
    if (e_issue && s.mr && s.rw && s.rd != 0) m_out.push_back(s.rd);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_ctrl} !==
        (e_issue ? {1'b1, s.rw, s.mr, s.ctrl} : {3'b000, 12'h0})) begin
      n_bad++;
      $display("FAIL ex_ctl: got v=%0b rw=%0b mr=%0b ctrl=%h, want issue=%0b rw=%0b mr=%0b ctrl=%h",
               ex_valid, ex_reg_write, ex_mem_read, ex_ctrl, e_issue, s.rw, s.mr, s.ctrl);
    end
    if (e_issue) begin
      n_cmp++;
      if ({ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} !==
          {e_d1, e_d2, 5'(s.rs1), 5'(s.rs2), 5'(s.rd)}) begin
        n_bad++;
        $display("FAIL ex_data: got %h %h a=%0d,%0d,%0d, want %h %h a=%0d,%0d,%0d",
                 ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
                 e_d1, e_d2, s.rs1, s.rs2, s.rd);
      end
    end
    n_cmp++;
    if (pending !== m_pending()) begin
      n_bad++;
      $display("FAIL pending: got %h, want %h", pending, m_pending());
    end
  endtask

  task automatic check_reset_outputs(string tag);
    n_cmp++;
    if ({ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
         ex_reg_write, ex_mem_read, pending, stall} !== '0 || if_write !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got ex_valid=%0b pending=%h stall=%0b if_write=%0b ctrl=%h, want all 0, if_write=1",
               tag, ex_valid, pending, stall, if_write, ex_ctrl);
    end
  endtask

  task automatic test_reset();
    drive(nop());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midrun();
    stim_t s = nop();
    s.wbw = 1; s.wbrd = 4; s.wbdata = 32'hCAFE_0004;
    step(s);
    step(load(8));
    n_cmp++;
    if (pending !== 32'h0000_0100 || ex_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_pre: got pending=%h ex_valid=%0b, want 00000100 1", pending, ex_valid);
    end
    @(negedge clk);
    drive(nop());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    step(alu(1, 4, 8));
    n_cmp++;
    if (ex_rs1_data !== 32'h0 || ex_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rf_after_reset: got rs1=%h valid=%0b, want 0 1", ex_rs1_data, ex_valid);
    end
  endtask

  task automatic test_load_use();
    stim_t s = nop();
    int stalls = 0;
    s.wbw = 1; s.wbrd = 7; s.wbdata = 32'h0000_0011;
    step(s);
    step(load(5));
    for (int c = 0; c < 3; c++) begin
      step(alu(6, 5, 7));
      if (obs_stall) stalls++;
    end
    s = alu(6, 5, 7);
    s.wbw = 1; s.wbrd = 5; s.wbld = 1; s.wbdata = 32'hDEAD_BEEF;
    step(s);
    n_cmp++;
    if (stalls != 3 || obs_stall !== 1'b0 || ex_rs1_data !== 32'hDEAD_BEEF || ex_rs2_data !== 32'h11) begin
      n_bad++;
      $display("FAIL load_use: got stalls=%0d last_stall=%0b rs1=%h rs2=%h, want 3 0 deadbeef 00000011",
               stalls, obs_stall, ex_rs1_data, ex_rs2_data);
    end
  endtask

  task automatic test_load_x0();
    stim_t s;
    step(load(0));
    s = alu(6, 0, 0);
    s.wbw = 1; s.wbrd = 0; s.wbdata = 32'h0000_1234;
    step(s);
    n_cmp++;
    if (pending !== 32'h0 || obs_stall !== 1'b0 || ex_rs1_data !== 32'h0) begin
      n_bad++;
      $display("FAIL load_x0: got pending=%h stall=%0b rs1=%h, want 0 0 0", pending, obs_stall, ex_rs1_data);
    end
  endtask

  task automatic test_flush();
    stim_t s;
    step(load(5));
    step(alu(6, 5, 7));
    s = alu(6, 5, 7);
    s.flush = 1;
    step(s);
    n_cmp++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b0 || pending !== 32'h0000_0020) begin
      n_bad++;
      $display("FAIL flush: got stall=%0b ex_valid=%0b pending=%h, want 0 0 00000020",
               obs_stall, ex_valid, pending);
    end
    s = nop();
    s.wbw = 1; s.wbrd = 5; s.wbld = 1; s.wbdata = 32'h5555_0005;
    step(s);
  endtask

  task automatic test_set_wins();
    stim_t s;
    step(load(9));
    s = load(9);
    s.wbw = 1; s.wbrd = 9; s.wbld = 1; s.wbdata = 32'h9999_0009;
    step(s);
    n_cmp++;
    if (obs_stall !== 1'b0 || pending[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL set_wins: got stall=%0b pending=%h, want 0 and bit9 set", obs_stall, pending);
    end
    s = nop();
    s.wbw = 1; s.wbrd = 9; s.wbld = 1; s.wbdata = 32'h9999_1009;
    step(s);
  endtask

  task automatic test_waw();
    stim_t s = nop();
    int stalls = 0;
    step(load(3));
    s.valid = 1; s.rd = 3; s.rw = 1; s.rs1 = 3; s.rs2 = 3; s.ctrl = 12'h811;
    repeat (2) begin
      step(s);
      if (obs_stall) stalls++;
    end
    s.wbw = 1; s.wbrd = 3; s.wbld = 1; s.wbdata = 32'h3333_0003;
    step(s);
    n_cmp++;
    if (stalls != 2 || obs_stall !== 1'b0 || ex_valid !== 1'b1 || pending !== 32'h0) begin
      n_bad++;
      $display("FAIL waw: got stalls=%0d last_stall=%0b ex_valid=%0b pending=%h, want 2 0 1 0",
               stalls, obs_stall, ex_valid, pending);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int n = 0; n < 400; n++) begin
      s = nop();
      s.valid  = ($urandom_range(0, 9) != 0);
      s.rs1    = $urandom_range(0, 7);
      s.rs2    = $urandom_range(0, 7);
      s.rs1u   = $urandom_range(0, 1);
      s.rs2u   = $urandom_range(0, 1);
      s.rd     = $urandom_range(0, 7);
      s.rw     = $urandom_range(0, 1);
      s.mr     = s.rw && ($urandom_range(0, 2) == 0);
      s.ctrl   = 12'($urandom);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.wbw    = $urandom_range(0, 1);
      s.wbrd   = $urandom_range(0, 7);
      s.wbdata = $urandom;
      s.wbld   = ($urandom_range(0, 9) == 0);
      if (m_out.size() != 0 && $urandom_range(0, 4) < 2) begin
        s.wbw  = 1;
        s.wbld = 1;
        s.wbrd = m_out[$urandom_range(0, m_out.size() - 1)];
      end
      step(s);
    end
  endtask

  initial begin
    drive(nop());
    test_reset();
    test_reset_midrun();
    test_load_use();
    test_load_x0();
    test_flush();
    test_set_wins();
    test_waw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
